// File: rtl/register_file.sv
// register_file: general-purpose register file feeding the ALU compare stage.
// Two combinational read ports and one synchronous write port. Register 0
// reads as zero and has no storage. WriteCount tracks committed writes and
// wraps silently at 8 bits.
module register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic [7:0]            WriteCount
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Register 0 is deliberately absent from the storage array.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic                  wr_commit;

    // A write commits only when enabled, aimed at a real register, and not
    // held in reset. X on WriteReg cannot leak through while RegWrite is 0.
    assign wr_commit = RegWrite && (WriteReg != '0) && !Reset;

    // Storage: async clear, one-cycle write of the addressed register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (WriteReg == ADDR_WIDTH'(i)) begin
                    regs[i] <= WriteData;
                end
            end
        end
    end

    // Committed-write counter; free-running 8-bit wrap with no flag.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            WriteCount <= '0;
        end else if (wr_commit) begin
            WriteCount <= WriteCount + 8'd1;
        end
    end

    // Read port 1: address decode, with optional write-through of WriteData.
    always_comb begin
        ReadData1 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ReadReg1 == ADDR_WIDTH'(i)) begin
                ReadData1 = regs[i];
            end
        end
        // wr_commit already excludes register 0, so reads of 0 stay zero.
        if ((BYPASS != 0) && wr_commit && (ReadReg1 == WriteReg)) begin
            ReadData1 = WriteData;
        end
    end

    // Read port 2: same structure as port 1.
    always_comb begin
        ReadData2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ReadReg2 == ADDR_WIDTH'(i)) begin
                ReadData2 = regs[i];
            end
        end
        if ((BYPASS != 0) && wr_commit && (ReadReg2 == WriteReg)) begin
            ReadData2 = WriteData;
        end
    end

endmodule
